uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter OVERSAMPLE, default 16, Baud_Tick pulses per bit period.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame (8N1 format, LSB first).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  high permits start-bit detection; low holds the block in IDLE once the current frame completes.
REQ-006 Baud_Tick  input  1  one-clk pulse at OVERSAMPLE x baud rate, from the shared baud generator.
REQ-007 R_X  input  1  asynchronous serial line; idles high.
REQ-008 data_ack  input  1  consumer acknowledge; clears data_valid.
REQ-009 data_out  output  8  last correctly framed byte; held until the next good frame.
REQ-010 data_valid  output  1  level; high from frame completion until data_ack.
REQ-011 framing_error  output  1  one-clk pulse when the stop bit samples low.
REQ-012 overrun  output  1  sticky; set when a good frame completes while data_valid is high and no data_ack arrives in that cycle.

Function
REQ-013 R_X shall pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-014 FSM states: IDLE, START, DATA, STOP.
REQ-015 IDLE->START on a falling edge of rx_s (prev 1, now 1->0) while enable=1; tick_cnt cleared to 0.
REQ-016 tick_cnt (4 bits) shall increment only on Baud_Tick and shall be cleared on every state transition.
REQ-017 START: on the Baud_Tick that completes OVERSAMPLE/2 ticks (mid start bit), if rx_s=0 go to DATA; otherwise go to IDLE (false start, no outputs change).
REQ-018 DATA: on every OVERSAMPLE-th Baud_Tick, sample rx_s into shift register bit bit_cnt (LSB first) and increment bit_cnt; after the DATA_BITS-th sample, go to STOP.
REQ-019 STOP: on the OVERSAMPLE-th Baud_Tick, sample rx_s and return to IDLE.
REQ-020 Stop sample = 1: on the next clk, load data_out from the shift register and set data_valid=1.
REQ-021 Stop sample = 0: on the next clk, pulse framing_error for 1 clk; data_out and data_valid unchanged.
REQ-022 data_ack=1 while data_valid=1 clears data_valid on the next clk; data_ack while data_valid=0 is ignored.
REQ-023 If data_ack and a good-frame completion occur in the same cycle, load the new byte, keep data_valid=1, and do not set overrun.
REQ-024 On a good frame while data_valid=1 without data_ack, overwrite data_out and set overrun; overrun clears only on reset.
REQ-025 Deasserting enable mid-frame does not abort the frame.
REQ-026 Latency: data_valid rises exactly 1 clk after the Baud_Tick that samples the stop bit.
REQ-027 A line held low after a framing error produces no new frame until rx_s returns high and falls again.

Reset
REQ-028 On reset: state=IDLE; tick_cnt=0; bit_cnt=0; shift register=0; data_out=8'h00; data_valid=0; framing_error=0; overrun=0; synchronizer flops=1.
REQ-029 Reset asserted mid-frame abandons the frame; no data_valid or framing_error is produced for it.

Structure
REQ-030 Shared package uart_pkg holds the state encodings (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11), OVERSAMPLE and DATA_BITS; the transmitter shares the same package.
REQ-031 The synchronizer is a sub-module, uart_sync_2ff; all other logic stays in uart_receiver.

Verification
REQ-032 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) at 16 ticks/bit -> data_out=8'hA5, data_valid=1 for 1 clk after the stop sample; framing_error=0.
REQ-033 Low glitch on R_X lasting 4 Baud_Ticks -> FSM returns to IDLE at the mid-start sample; data_valid and framing_error stay 0.
REQ-034 Frame 0x3C with stop bit driven 0 -> framing_error pulses 1 clk; data_out keeps its prior value; data_valid unchanged.
REQ-035 Frames 0x11 then 0x22 without data_ack -> data_out=8'h22 and overrun=1; repeat with data_ack coincident with 0x22 completion -> overrun stays 0.
REQ-036 Reset asserted during DATA bit 4 of 0xFF -> all outputs at reset values; a following frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and frame defaults
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;

endpackage

// File: rtl/uart_sync_2ff.sv
// rtl/uart_sync_2ff.sv - two-flop synchronizer for the idle-high serial line
module uart_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
    end

    // Flops reset high so a reset never looks like a start-bit edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampled 8N1 UART receiver with valid/ack handshake
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 Baud_Tick,
    input  logic                 R_X,
    input  logic                 data_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 overrun
);

    localparam int              BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [3:0]      TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]      TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]   BIT_LAST  = BW'(DATA_BITS - 1);

    logic rx_s;

    uart_sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (R_X),
        .q     (rx_s)
    );

    uart_state_e          state_q, state_d;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 framing_error_q, framing_error_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_prev_q, rx_prev_d;
    logic                 frame_good;

    always_comb begin
        state_d         = state_q;
        tick_cnt_d      = tick_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        data_out_d      = data_out_q;
        data_valid_d    = data_valid_q;
        framing_error_d = 1'b0;
        overrun_d       = overrun_q;
        rx_prev_d       = rx_s;
        frame_good      = 1'b0;

        if (Baud_Tick && state_q != IDLE) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (enable && rx_prev_q && !rx_s) begin
                    state_d    = START;
                    tick_cnt_d = 4'd0;
                    bit_cnt_d  = '0;
                end
            end
            START: begin
                if (Baud_Tick && tick_cnt_q == TICK_MID) begin
                    state_d    = rx_s ? IDLE : DATA;
                    tick_cnt_d = 4'd0;
                end
            end
            DATA: begin
                if (Baud_Tick && tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d         = 4'd0;
                    shift_d[bit_cnt_q] = rx_s;
                    bit_cnt_d          = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (Baud_Tick && tick_cnt_q == TICK_LAST) begin
                    state_d         = IDLE;
                    tick_cnt_d      = 4'd0;
                    frame_good      = rx_s;
                    framing_error_d = !rx_s;
                end
            end
            default: state_d = IDLE;
        endcase

        // A coincident ack consumes the old byte, so it cannot count as an overrun.
        if (frame_good) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            if (data_valid_q && !data_ack) begin
                overrun_d = 1'b1;
            end
        end else if (data_ack) begin
            data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            tick_cnt_q      <= 4'd0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            data_out_q      <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
            rx_prev_q       <= 1'b1;
        end else begin
            state_q         <= state_d;
            tick_cnt_q      <= tick_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            data_out_q      <= data_out_d;
            data_valid_q    <= data_valid_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
            rx_prev_q       <= rx_prev_d;
        end
    end

    assign data_out      = data_out_q;
    assign data_valid    = data_valid_q;
    assign framing_error = framing_error_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

    localparam int OS        = 16;
    localparam int NB        = 8;
    localparam int STOP_TICK = OS / 2 + NB * OS + OS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       Baud_Tick = 1'b0;
    logic       R_X = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_error;
    logic       overrun;

    uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(NB)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .Baud_Tick     (Baud_Tick),
        .R_X           (R_X),
        .data_ack      (data_ack),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int fe_cycles = 0;
    int abort_tick = 0;
    int drop_en_tick = 0;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovr;

    logic [7:0] dout_after;
    logic       dv_before, dv_after, fe_before, fe_after, ov_after;

    always #5 clk = ~clk;

    initial begin
        int div = 0;
        forever begin
            @(posedge clk);
            #1;
            div = (div == 3) ? 0 : div + 1;
            Baud_Tick = (div == 0);
        end
    end

    always @(negedge clk) begin
        if (framing_error === 1'b1) fe_cycles++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (Baud_Tick !== 1'b1 && n < 64);
        if (Baud_Tick !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL baud_timeout: no Baud_Tick within %0d cycles", n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        data_ack = 1'b0;
        R_X = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_data = 8'h00;
        m_valid = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic pulse_ack();
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        m_valid = 1'b0;
    endtask

    // Drives start, data LSB first, stop; captures outputs around the stop sample tick.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit ack_at_stop);
        logic [9:0] bits;
        int t = 0;
        bits = {stop_bit, b, 1'b0};
        wait_tick();
        R_X = bits[0];
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < OS; k++) begin
                wait_tick();
                t++;
                if (abort_tick != 0 && t == abort_tick) begin
                    reset = 1'b1;
                    repeat (3) @(negedge clk);
                    reset = 1'b0;
                    R_X = 1'b1;
                    return;
                end
                if (drop_en_tick != 0 && t == drop_en_tick) enable = 1'b0;
                if (t == STOP_TICK) begin
                    dv_before = data_valid;
                    fe_before = framing_error;
                    if (ack_at_stop) data_ack = 1'b1;
                    @(negedge clk);
                    data_ack = 1'b0;
                    dout_after = data_out;
                    dv_after = data_valid;
                    fe_after = framing_error;
                    ov_after = overrun;
                end
            end
            if (i < 9) R_X = bits[i+1];
        end
    endtask

    // Reference rule for a well-framed byte arriving at the consumer.
    task automatic model_good(input logic [7:0] b, input bit ack);
        if (m_valid && !ack) m_ovr = 1'b1;
        m_data = b;
        m_valid = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({data_out, data_valid, framing_error, overrun} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 000", {data_out, data_valid, framing_error, overrun});
        end
    endtask

    task automatic test_frame_a5();
        enable = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0);
        model_good(8'hA5, 1'b0);
        n_cmp++;
        if (dv_before !== 1'b0) begin
            n_bad++; $display("FAIL a5_latency_early: valid=%b required 0 on stop tick", dv_before);
        end
        n_cmp++;
        if (dout_after !== 8'hA5 || dv_after !== 1'b1) begin
            n_bad++; $display("FAIL a5_data: got %h/%b required a5/1", dout_after, dv_after);
        end
        n_cmp++;
        if (fe_after !== 1'b0) begin
            n_bad++; $display("FAIL a5_fe: got %b required 0", fe_after);
        end
        pulse_ack();
        n_cmp++;
        if (data_valid !== 1'b0) begin
            n_bad++; $display("FAIL a5_ack_clear: valid=%b required 0", data_valid);
        end
    endtask

    task automatic test_false_start();
        int fe0;
        logic [7:0] b;
        fe0 = fe_cycles;
        wait_tick();
        R_X = 1'b0;
        repeat (4) wait_tick();
        R_X = 1'b1;
        repeat (40) wait_tick();
        n_cmp++;
        if (data_valid !== m_valid || fe_cycles != fe0) begin
            n_bad++; $display("FAIL glitch_quiet: valid=%b fe_cycles=%0d required %b/%0d", data_valid, fe_cycles, m_valid, fe0);
        end
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0);
        model_good(b, 1'b0);
        n_cmp++;
        if (dout_after !== m_data || dv_after !== 1'b1) begin
            n_bad++; $display("FAIL glitch_recover: got %h/%b required %h/1", dout_after, dv_after, m_data);
        end
        pulse_ack();
    endtask

    task automatic test_framing_error();
        int fe0;
        logic [7:0] b;
        fe0 = fe_cycles;
        send_frame(8'h3C, 1'b0, 1'b0);
        n_cmp++;
        if (fe_before !== 1'b0 || fe_after !== 1'b1) begin
            n_bad++; $display("FAIL fe_pulse: before=%b after=%b required 0/1", fe_before, fe_after);
        end
        n_cmp++;
        if (dout_after !== m_data || dv_after !== m_valid) begin
            n_bad++; $display("FAIL fe_hold: got %h/%b required %h/%b", dout_after, dv_after, m_data, m_valid);
        end
        repeat (48) wait_tick();
        n_cmp++;
        if (fe_cycles != fe0 + 1 || data_valid !== m_valid) begin
            n_bad++; $display("FAIL fe_line_low: fe_cycles=%0d valid=%b required %0d/%b", fe_cycles, data_valid, fe0 + 1, m_valid);
        end
        R_X = 1'b1;
        repeat (4) wait_tick();
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0);
        model_good(b, 1'b0);
        n_cmp++;
        if (dout_after !== m_data || dv_after !== 1'b1) begin
            n_bad++; $display("FAIL fe_recover: got %h/%b required %h/1", dout_after, dv_after, m_data);
        end
        pulse_ack();
    endtask

    task automatic test_overrun();
        do_reset();
        enable = 1'b1;
        send_frame(8'h11, 1'b1, 1'b0);
        model_good(8'h11, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        model_good(8'h22, 1'b0);
        n_cmp++;
        if (dout_after !== 8'h22 || ov_after !== 1'b1 || m_ovr !== 1'b1) begin
            n_bad++; $display("FAIL overrun_set: got %h/%b required 22/1", dout_after, ov_after);
        end
        do_reset();
        send_frame(8'h11, 1'b1, 1'b0);
        model_good(8'h11, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        model_good(8'h22, 1'b1);
        n_cmp++;
        if (dout_after !== 8'h22 || dv_after !== 1'b1 || ov_after !== m_ovr) begin
            n_bad++; $display("FAIL overrun_ack: got %h/%b/%b required 22/1/%b", dout_after, dv_after, ov_after, m_ovr);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] b;
        bit ack;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            send_frame(b, 1'b1, ack);
            n_cmp++;
            if (dv_before !== m_valid) begin
                n_bad++; $display("FAIL rand%0d_pre_valid: got %b required %b", i, dv_before, m_valid);
            end
            model_good(b, ack);
            n_cmp++;
            if (dout_after !== m_data || dv_after !== 1'b1 || ov_after !== m_ovr || fe_after !== 1'b0) begin
                n_bad++; $display("FAIL rand%0d_frame: got %h/%b/%b/%b required %h/1/%b/0", i, dout_after, dv_after, ov_after, fe_after, m_data, m_ovr);
            end
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                n_cmp++;
                if (data_valid !== 1'b0) begin
                    n_bad++; $display("FAIL rand%0d_ack: valid=%b required 0", i, data_valid);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int fe0;
        do_reset();
        enable = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0);
        abort_tick = OS / 2 + 4 * OS + OS / 2;
        send_frame(8'hFF, 1'b1, 1'b0);
        abort_tick = 0;
        m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
        n_cmp++;
        if ({data_out, data_valid, framing_error, overrun} !== 11'h0) begin
            n_bad++; $display("FAIL abort_reset: got %h required 000", {data_out, data_valid, framing_error, overrun});
        end
        fe0 = fe_cycles;
        repeat (160) wait_tick();
        n_cmp++;
        if (data_valid !== 1'b0 || fe_cycles != fe0) begin
            n_bad++; $display("FAIL abort_quiet: valid=%b fe_cycles=%0d required 0/%0d", data_valid, fe_cycles, fe0);
        end
        send_frame(8'h5A, 1'b1, 1'b0);
        model_good(8'h5A, 1'b0);
        n_cmp++;
        if (dout_after !== 8'h5A || dv_after !== 1'b1 || ov_after !== 1'b0) begin
            n_bad++; $display("FAIL abort_next: got %h/%b/%b required 5a/1/0", dout_after, dv_after, ov_after);
        end
        pulse_ack();
    endtask

    task automatic test_enable();
        logic [7:0] b;
        enable = 1'b0;
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0);
        n_cmp++;
        if (dv_after !== 1'b0 || dout_after !== m_data) begin
            n_bad++; $display("FAIL enable_low: got %h/%b required %h/0", dout_after, dv_after, m_data);
        end
        enable = 1'b1;
        drop_en_tick = 50;
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0);
        drop_en_tick = 0;
        model_good(b, 1'b0);
        n_cmp++;
        if (dout_after !== m_data || dv_after !== 1'b1) begin
            n_bad++; $display("FAIL enable_drop: got %h/%b required %h/1", dout_after, dv_after, m_data);
        end
        enable = 1'b1;
    endtask

    initial begin
        m_data = 8'h00;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        test_reset();
        test_frame_a5();
        test_false_start();
        test_framing_error();
        test_overrun();
        test_random_frames();
        test_reset_mid_frame();
        test_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
